word_to_byte_tx: RTL

//  Transmit-side 32->8 unpacker of the PHY data path.
//  - Accepts 32-bit words from the logic layer over a valid/ready handshake.
//  - Emits them as 8-bit bytes, one per clk_4f cycle, MSB byte first ([31:24], [23:16], [15:8], [7:0]).
//  - This byte order matches the receive-side 8->32 packer.
//  - A one-word holding buffer sustains gap-free streaming at one word per 4 clk_4f cycles.

---
 rtl/word_to_byte_tx.sv | 103 ++++++++++
 1 files changed

// File: rtl/word_to_byte_tx.sv
// ---------------------------------------------------------------------------
// word_to_byte_tx
//   Transmit-side 32->8 unpacker. Accepts whole words on a valid/ready
//   handshake and emits them one byte per clk_4f cycle, most significant
//   byte first, matching the byte order of the receive-side packer. A
//   one-word holding buffer lets the next word be taken while the current
//   one is still being emitted, so back-to-back words stream with no gaps.
//
// Ports
//   clk_4f     in   byte-rate clock, all logic on its rising edge
//   reset      in   asynchronous reset, active low
//   data_in    in   word from upstream
//   valid_in   in   data_in is valid
//   ready_out  out  block can take a word this cycle (registered state only)
//   data_out   out  byte to the line side, registered
//   valid_out  out  data_out is valid, registered
//   busy       out  a word is mid-emission or a word is held
// ---------------------------------------------------------------------------
module word_to_byte_tx #(
  parameter int unsigned        BYTE_W   = 8,
  parameter int unsigned        NBYTES   = 4,
  parameter logic [BYTE_W-1:0]  IDLE_VAL = '0
) (
  input  logic                     clk_4f,
  input  logic                     reset,
  input  logic [BYTE_W*NBYTES-1:0] data_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [BYTE_W-1:0]        data_out,
  output logic                     valid_out,
  output logic                     busy
);

  localparam int unsigned WORD_W = BYTE_W * NBYTES;
  localparam int unsigned CNT_W  = $clog2(NBYTES);

  // Index of the most significant byte; also the last value cnt reaches.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  // Word viewed as an array of bytes; element LAST is bits [WORD_W-1 -: BYTE_W].
  typedef logic [NBYTES-1:0][BYTE_W-1:0] word_t;

  word_t            shreg;   // word currently being emitted
  word_t            hold;    // next word, waiting for the current one to finish
  logic             hold_v;
  logic [CNT_W-1:0] cnt;     // index of the next byte of shreg to emit
  logic             active;
  logic             accept;

  // cnt only leaves zero once the first byte of a word has gone out, and
  // returns to zero as the last byte goes out, so a non-zero count is
  // exactly "a word is part-way through".
  assign active    = (cnt != '0);
  assign ready_out = ~hold_v;
  assign accept    = valid_in & ready_out;
  assign busy      = active | hold_v;

  // NOTE: all state here is sequential, so every assignment in this block is
  // non-blocking; blocking assignments would let later statements see
  // this-cycle values and break the register semantics.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      hold      <= '0;
      hold_v    <= 1'b0;
      cnt       <= '0;
      data_out  <= IDLE_VAL;
      valid_out <= 1'b0;
    end else if (active) begin
      // Mid-word: keep streaming; a partially sent word never stalls.
      data_out  <= shreg[LAST - cnt];
      valid_out <= 1'b1;
      cnt       <= (cnt == LAST) ? '0 : cnt + ONE;
      if (accept) begin
        hold   <= data_in;
        hold_v <= 1'b1;
      end
    end else if (hold_v) begin
      // Word boundary with a held word: start it straight away.
      shreg     <= hold;
      data_out  <= hold[LAST];
      valid_out <= 1'b1;
      cnt       <= ONE;
      if (accept) begin
        hold <= data_in;
      end else begin
        hold_v <= 1'b0;
      end
    end else if (accept) begin
      // Word boundary, pipe empty: cut-through, first byte goes out at once.
      shreg     <= data_in;
      data_out  <= data_in[WORD_W-1 -: BYTE_W];
      valid_out <= 1'b1;
      cnt       <= ONE;
    end else begin
      // Underrun: nothing to send this cycle.
      data_out  <= IDLE_VAL;
      valid_out <= 1'b0;
    end
  end

endmodule
